// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan/average block.
// The clamp helper turns a signed ADC result into a non-negative magnitude.
package adc_pkg;

    typedef enum logic [2:0] {
        TRIGGER    = 3'd0,
        WAIT_START = 3'd1,
        WAIT_DONE  = 3'd2,
        ACCUM      = 3'd3,
        PUBLISH    = 3'd4,
        ABORT      = 3'd5
    } state_e;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam int VOLT_W = 15;

    // Negative readings carry no useful voltage for the loop, so they count as zero.
    function automatic logic [VOLT_W-1:0] clamp_sample(input logic [15:0] raw);
        logic [VOLT_W-1:0] res;
        if (raw[15]) begin
            res = {VOLT_W{1'b0}};
        end else begin
            res = raw[VOLT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_scan_averager.sv
// Alternates conversions between ADC channels 0 and 1, averages 2^AVG_LOG2
// clamped samples per channel and publishes both averages with a one-cycle strobe.
module adc_scan_averager
    import adc_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [15:0]       adc_data,
    input  logic              adc_ready,
    output logic              adc_enable,
    output logic [1:0]        adc_channel,
    output logic [VOLT_W-1:0] volt_ch1,
    output logic [VOLT_W-1:0] volt_ch2,
    output logic              avg_valid,
    output logic              timeout_err
);

    localparam int ACC_W = VOLT_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(32'd1);

    state_e             state_q,       state_d;
    logic               adc_enable_q,  adc_enable_d;
    logic [1:0]         adc_channel_q, adc_channel_d;
    logic [VOLT_W-1:0]  volt_ch1_q,    volt_ch1_d;
    logic [VOLT_W-1:0]  volt_ch2_q,    volt_ch2_d;
    logic               avg_valid_q,   avg_valid_d;
    logic               timeout_err_q, timeout_err_d;
    logic [ACC_W-1:0]   acc0_q,        acc0_d;
    logic [ACC_W-1:0]   acc1_q,        acc1_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [TMR_W-1:0]   timer_q,       timer_d;
    logic [VOLT_W-1:0]  sample_q,      sample_d;

    // State and datapath registers; reset discards any result in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= TRIGGER;
            adc_enable_q  <= 1'b0;
            adc_channel_q <= CH0;
            volt_ch1_q    <= {VOLT_W{1'b0}};
            volt_ch2_q    <= {VOLT_W{1'b0}};
            avg_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            acc0_q        <= {ACC_W{1'b0}};
            acc1_q        <= {ACC_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            timer_q       <= {TMR_W{1'b0}};
            sample_q      <= {VOLT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            adc_enable_q  <= adc_enable_d;
            adc_channel_q <= adc_channel_d;
            volt_ch1_q    <= volt_ch1_d;
            volt_ch2_q    <= volt_ch2_d;
            avg_valid_q   <= avg_valid_d;
            timeout_err_q <= timeout_err_d;
            acc0_q        <= acc0_d;
            acc1_q        <= acc1_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            sample_q      <= sample_d;
        end
    end

    // Conversion sequencing, accumulation, publishing and timeout recovery.
    always_comb begin
        state_d       = state_q;
        adc_enable_d  = adc_enable_q;
        adc_channel_d = adc_channel_q;
        volt_ch1_d    = volt_ch1_q;
        volt_ch2_d    = volt_ch2_q;
        avg_valid_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        acc0_d        = acc0_q;
        acc1_d        = acc1_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        sample_d      = sample_q;

        case (state_q)
            TRIGGER: begin
                adc_enable_d = 1'b1;
                timer_d      = {TMR_W{1'b0}};
                state_d      = WAIT_START;
            end
            WAIT_START: begin
                if (!adc_ready) begin
                    timer_d = {TMR_W{1'b0}};
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            WAIT_DONE: begin
                if (adc_ready) begin
                    sample_d = clamp_sample(adc_data);
                    state_d  = ACCUM;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ACCUM: begin
                adc_enable_d = 1'b0;
                if (adc_channel_q == CH0) begin
                    acc0_d        = acc0_q + ACC_W'(sample_q);
                    adc_channel_d = CH1;
                    state_d       = TRIGGER;
                end else begin
                    // A block ends only after a channel-1 sample, so both channels have equal counts.
                    acc1_d        = acc1_q + ACC_W'(sample_q);
                    adc_channel_d = CH0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = PUBLISH;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = TRIGGER;
                    end
                end
            end
            PUBLISH: begin
                volt_ch1_d  = VOLT_W'(acc0_q >> AVG_LOG2);
                volt_ch2_d  = VOLT_W'(acc1_q >> AVG_LOG2);
                avg_valid_d = 1'b1;
                acc0_d      = {ACC_W{1'b0}};
                acc1_d      = {ACC_W{1'b0}};
                state_d     = TRIGGER;
            end
            ABORT: begin
                adc_enable_d  = 1'b0;
                timeout_err_d = 1'b1;
                acc0_d        = {ACC_W{1'b0}};
                acc1_d        = {ACC_W{1'b0}};
                cnt_d         = {CNT_W{1'b0}};
                adc_channel_d = CH0;
                state_d       = TRIGGER;
            end
            default: begin
                state_d = TRIGGER;
            end
        endcase
    end

    assign adc_enable  = adc_enable_q;
    assign adc_channel = adc_channel_q;
    assign volt_ch1    = volt_ch1_q;
    assign volt_ch2    = volt_ch2_q;
    assign avg_valid   = avg_valid_q;
    assign timeout_err = timeout_err_q;

endmodule
